// File: rtl/unit_launch_seq.sv
`default_nettype none
// =============================================================================
// unit_launch_seq : holds units in reset, releases enabled units, staggers start
//                   pulses and aggregates busy. Optional: UNIT_LAUNCH_TIMEOUT_EN
// Rev 1.0
// =============================================================================
module unit_launch_seq #(
  parameter int NU       = 4,
  parameter int RST_CYC  = 4,
  parameter int STAGGER  = 2,
  parameter int DRAIN    = 3,
  parameter int TMO_BITS = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    num_units,
  input  logic [NU-1:0] unit_busy,
  output logic [NU-1:0] unit_reset,
  output logic [NU-1:0] unit_start,
  output logic          busy,
  output logic          launch_err,
  output logic          timeout
);

  localparam int IW = (NU > 1) ? $clog2(NU) : 1;
  localparam logic [NU-1:0] c_one = NU'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RST    = 2'd1,
    S_LAUNCH = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  if (NU < 1 || NU > 16 || RST_CYC < 1 || RST_CYC > 15 || STAGGER < 1 ||
      STAGGER > 15 || DRAIN < 1 || DRAIN > 15 || TMO_BITS < 2) begin : g_param_err
    $error("unit_launch_seq: parameter out of range");
  end

  state_t        r_state;
  logic [NU-1:0] r_en;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_last;
  logic [3:0]    r_cnt;
  logic [3:0]    r_gap;
  logic [3:0]    r_quiet;
  logic [NU-1:0] w_en;
  logic [4:0]    w_n_en;
  logic [IW-1:0] w_last;
  logic          w_tmo_hit;

  // Clamp requested count to the physical array and build the low-bits mask
  always_comb begin
    w_n_en = (num_units > 8'(NU)) ? 5'(NU) : num_units[4:0];
    w_en   = '0;
    for (int i = 0; i < NU; i++) begin
      w_en[i] = (5'(i) < w_n_en);
    end
    w_last = IW'(w_n_en - 5'd1);
  end

`ifdef UNIT_LAUNCH_TIMEOUT_EN
  logic [TMO_BITS-1:0] r_wdog;
  logic [TMO_BITS-1:0] w_wdog_inc;
  logic                r_timeout;

  assign w_wdog_inc = r_wdog + TMO_BITS'(1);
  assign w_tmo_hit  = (r_state == S_RUN) && (&w_wdog_inc);
  assign timeout    = r_timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_wdog <= w_wdog_inc;
      if (w_tmo_hit) r_timeout <= 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_en       <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_quiet    <= '0;
      unit_reset <= '1;
      unit_start <= '0;
      busy       <= 1'b0;
      launch_err <= 1'b0;
    end else begin
      unit_start <= '0;
      launch_err <= start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          unit_reset <= '1;
          busy       <= 1'b0;
          if (start) begin
            r_en    <= w_en;
            r_last  <= w_last;
            r_cnt   <= 4'(RST_CYC);
            busy    <= 1'b1;
            r_state <= S_RST;
          end
        end
        S_RST: begin
          if (r_cnt == 4'd1) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_gap      <= 4'(STAGGER - 1);
            r_quiet    <= '0;
            unit_reset <= ~r_en;
            if (r_en == '0) begin
              r_state <= S_RUN;
            end else begin
              r_state    <= S_LAUNCH;
              unit_start <= c_one;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_LAUNCH: begin
          // The cycle showing the last pulse is also the last LAUNCH cycle
          if (r_idx == r_last) begin
            r_state <= S_RUN;
            r_quiet <= '0;
          end else if (r_gap == 4'd0) begin
            r_idx      <= r_idx + IW'(1);
            unit_start <= c_one << (r_idx + IW'(1));
            r_gap      <= 4'(STAGGER - 1);
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        S_RUN: begin
          if (w_tmo_hit) begin
            r_state    <= S_IDLE;
            unit_reset <= '1;
            busy       <= 1'b0;
          end else if ((unit_busy & r_en) == '0) begin
            if (r_quiet == 4'(DRAIN - 1)) begin
              r_state    <= S_IDLE;
              r_quiet    <= '0;
              unit_reset <= '1;
              busy       <= 1'b0;
            end else begin
              r_quiet <= r_quiet + 4'd1;
            end
          end else begin
            r_quiet <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unit_launch_seq.sv
`default_nettype none
// =============================================================================
// tb_unit_launch_seq : directed cycle-by-cycle checks of launch sequencing
// Rev 1.0
// =============================================================================
module tb_unit_launch_seq;

  localparam int NU = 4;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [7:0]    num_units;
  logic [NU-1:0] unit_busy;
  logic [NU-1:0] unit_reset;
  logic [NU-1:0] unit_start;
  logic          busy;
  logic          launch_err;
  logic          timeout;

  int n_checks = 0;
  int n_fails  = 0;

  unit_launch_seq #(
    .NU(NU), .RST_CYC(4), .STAGGER(2), .DRAIN(3), .TMO_BITS(20)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_units  (num_units),
    .unit_busy  (unit_busy),
    .unit_reset (unit_reset),
    .unit_start (unit_start),
    .busy       (busy),
    .launch_err (launch_err),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scenario ids: 1 full launch, 2 partial with busy, 3 none enabled,
  // 4 clamped count, 5 extra start, 6 mid-launch reset.
  task automatic run_scn(input int id, input logic [7:0] nu, input int ncyc);
    logic [NU-1:0] e_reset, e_start;
    logic          e_busy, e_err;
    for (int c = 0; c <= ncyc; c++) begin
      start     = (c == 0) || (id == 5 && c == 9);
      num_units = nu;
      reset_n   = !(id == 6 && c == 8);
      unit_busy = '0;
      if (id == 2) unit_busy = {1'b1, 1'b0, (c >= 6 && c <= 20), 1'b0};

      e_start = '0;
      e_err   = (id == 5 && c == 10);
      case (id)
        2: begin
          e_reset = (c >= 5 && c <= 23) ? 4'b1100 : 4'hF;
          e_busy  = (c >= 1 && c <= 23);
          if (c == 5) e_start = 4'b0001;
          if (c == 7) e_start = 4'b0010;
        end
        3: begin
          e_reset = 4'hF;
          e_busy  = (c >= 1 && c <= 7);
        end
        6: begin
          e_reset = (c >= 5 && c <= 8) ? 4'h0 : 4'hF;
          e_busy  = (c >= 1 && c <= 8);
          if (c == 5) e_start = 4'b0001;
          if (c == 7) e_start = 4'b0010;
        end
        default: begin
          e_reset = (c >= 5 && c <= 14) ? 4'h0 : 4'hF;
          e_busy  = (c >= 1 && c <= 14);
          if (c == 5)  e_start = 4'b0001;
          if (c == 7)  e_start = 4'b0010;
          if (c == 9)  e_start = 4'b0100;
          if (c == 11) e_start = 4'b1000;
        end
      endcase

      check_value($sformatf("s%0d_c%0d_unit_reset", id, c), 32'(unit_reset), 32'(e_reset));
      check_value($sformatf("s%0d_c%0d_unit_start", id, c), 32'(unit_start), 32'(e_start));
      check_value($sformatf("s%0d_c%0d_busy", id, c), 32'(busy), 32'(e_busy));
      check_value($sformatf("s%0d_c%0d_launch_err", id, c), 32'(launch_err), 32'(e_err));
      check_value($sformatf("s%0d_c%0d_timeout", id, c), 32'(timeout), 32'd0);

      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    num_units = 8'd0;
    unit_busy = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_unit_reset", 32'(unit_reset), 32'hF);
    check_value("reset_unit_start", 32'(unit_start), 32'h0);
    check_value("reset_busy", 32'(busy), 32'h0);
    check_value("reset_launch_err", 32'(launch_err), 32'h0);
    check_value("reset_timeout", 32'(timeout), 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_scn(1, 8'd4, 17);
    run_scn(2, 8'd2, 26);
    run_scn(3, 8'd0, 10);
    run_scn(4, 8'd9, 17);
    run_scn(5, 8'd4, 17);
    run_scn(6, 8'd4, 12);
    run_scn(1, 8'd4, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
